// File: rtl/exmem_pipe_reg.sv
// EX/MEM pipeline register: STAGES chained stages carrying {v, wb, mem, alu, d2, rd},
// with bubble insertion on flush, a flush deferred across stalls, and a saturating stall counter.
module exmem_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int WB_W   = 2,
  parameter int STAGES = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [WB_W-1:0]   WBCtrl_i,
  input  logic [1:0]        MemCtrl_i,
  input  logic [DATA_W-1:0] ALU_i,
  input  logic [DATA_W-1:0] Data2_i,
  input  logic [REG_W-1:0]  RegRd_i,
  output logic              valid_o,
  output logic [WB_W-1:0]   WBCtrl_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic [DATA_W-1:0] ALU_o,
  output logic [DATA_W-1:0] Data2_o,
  output logic [REG_W-1:0]  RegRd_o,
  output logic              flush_pend_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef struct packed {
    logic              v;
    logic [WB_W-1:0]   wb;
    logic [1:0]        mem;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] d2;
    logic [REG_W-1:0]  rd;
  } stage_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  stage_t             entry_next;
  stage_t             chain [STAGES];
  stage_t             out_stage;
  logic               flush_pend_reg;
  logic [CNT_W-1:0]   stall_cnt_reg;

  // A killed or invalid instruction enters as an all-zero bubble, data included.
  always_comb begin
    entry_next = '0;
    if (valid_i && !(flush_i || flush_pend_reg)) begin
      entry_next.v   = 1'b1;
      entry_next.wb  = WBCtrl_i;
      entry_next.mem = MemCtrl_i;
      entry_next.alu = ALU_i;
      entry_next.d2  = Data2_i;
      entry_next.rd  = RegRd_i;
    end
  end

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      stage_t stage_reg;
      stage_t stage_next;

      if (gi == 0) begin : g_head
        assign stage_next = entry_next;
      end else begin : g_tail
        assign stage_next = chain[gi-1];
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          stage_reg <= '0;
        end else if (!stall_i) begin
          stage_reg <= stage_next;
        end
      end

      assign chain[gi] = stage_reg;
    end
  endgenerate

  // A flush seen while stalled is remembered and consumed by the next moving edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flush_pend_reg <= 1'b0;
    end else if (stall_i) begin
      if (flush_i) begin
        flush_pend_reg <= 1'b1;
      end
    end else begin
      flush_pend_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_reg <= '0;
    end else if (stall_i && (stall_cnt_reg != CNT_MAX)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
    end
  end

  assign out_stage    = chain[STAGES-1];
  assign valid_o      = out_stage.v;
  assign WBCtrl_o     = out_stage.wb & {WB_W{out_stage.v}};
  assign MemRead_o    = out_stage.v & out_stage.mem[0];
  assign MemWrite_o   = out_stage.v & out_stage.mem[1];
  assign ALU_o        = out_stage.alu;
  assign Data2_o      = out_stage.d2;
  assign RegRd_o      = out_stage.rd;
  assign flush_pend_o = flush_pend_reg;
  assign stall_cnt_o  = stall_cnt_reg;

endmodule

// File: tb/tb_exmem_pipe_reg.sv
// Bench for exmem_pipe_reg: single-stage, three-stage and 4-bit-counter instances share stimulus;
// expected stage contents are queued as they are driven and popped as they reach the outputs.
module tb_exmem_pipe_reg;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        valid;
  logic [1:0]  wb;
  logic [1:0]  mem;
  logic [31:0] alu;
  logic [31:0] d2;
  logic [4:0]  rd;

  logic        a_valid, a_mr, a_mw, a_fp;
  logic [1:0]  a_wb;
  logic [31:0] a_alu, a_d2;
  logic [4:0]  a_rd;
  logic [15:0] a_cnt;

  logic        b_valid, b_mr, b_mw, b_fp;
  logic [1:0]  b_wb;
  logic [31:0] b_alu, b_d2;
  logic [4:0]  b_rd;
  logic [15:0] b_cnt;

  logic        c_valid, c_mr, c_mw, c_fp;
  logic [1:0]  c_wb;
  logic [31:0] c_alu, c_d2;
  logic [4:0]  c_rd;
  logic [3:0]  c_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        v;
    logic [1:0]  wb;
    logic [1:0]  mem;
    logic [31:0] alu;
    logic [31:0] d2;
    logic [4:0]  rd;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  logic pend_m;

  exmem_pipe_reg #(.STAGES(1)) u_d1 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(valid),
    .WBCtrl_i(wb), .MemCtrl_i(mem), .ALU_i(alu), .Data2_i(d2), .RegRd_i(rd),
    .valid_o(a_valid), .WBCtrl_o(a_wb), .MemRead_o(a_mr), .MemWrite_o(a_mw),
    .ALU_o(a_alu), .Data2_o(a_d2), .RegRd_o(a_rd), .flush_pend_o(a_fp), .stall_cnt_o(a_cnt)
  );

  exmem_pipe_reg #(.STAGES(3)) u_d3 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(valid),
    .WBCtrl_i(wb), .MemCtrl_i(mem), .ALU_i(alu), .Data2_i(d2), .RegRd_i(rd),
    .valid_o(b_valid), .WBCtrl_o(b_wb), .MemRead_o(b_mr), .MemWrite_o(b_mw),
    .ALU_o(b_alu), .Data2_o(b_d2), .RegRd_o(b_rd), .flush_pend_o(b_fp), .stall_cnt_o(b_cnt)
  );

  exmem_pipe_reg #(.STAGES(1), .CNT_W(4)) u_dc (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(valid),
    .WBCtrl_i(wb), .MemCtrl_i(mem), .ALU_i(alu), .Data2_i(d2), .RegRd_i(rd),
    .valid_o(c_valid), .WBCtrl_o(c_wb), .MemRead_o(c_mr), .MemWrite_o(c_mw),
    .ALU_o(c_alu), .Data2_o(c_d2), .RegRd_o(c_rd), .flush_pend_o(c_fp), .stall_cnt_o(c_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t bubble();
    exp_t e;
    e.v = 1'b0; e.wb = 2'b00; e.mem = 2'b00; e.alu = 32'h0; e.d2 = 32'h0; e.rd = 5'd0;
    return e;
  endfunction

  // Reset with every input nonzero; afterwards the 3-stage pipe holds two leading bubbles.
  task automatic do_reset();
    rst = 1'b1; stall = 1'b1; flush = 1'b1; valid = 1'b1;
    wb = 2'b11; mem = 2'b11; alu = 32'hFFFF_FFFF; d2 = 32'hFFFF_FFFF; rd = 5'h1F;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; stall = 1'b0; flush = 1'b0; valid = 1'b0;
    wb = 2'b00; mem = 2'b00; alu = 32'h0; d2 = 32'h0; rd = 5'd0;
    q1.delete();
    q3.delete();
    q3.push_back(bubble());
    q3.push_back(bubble());
    pend_m = 1'b0;
  endtask

  // One clock edge of stimulus; queues the entry the spec says stage 0 loads.
  task automatic cycle(input logic v, input logic st, input logic fl,
                       input logic [1:0] m, input logic [31:0] a, input logic [4:0] r);
    exp_t e;
    valid = v; stall = st; flush = fl; mem = m; alu = a; d2 = ~a; rd = r; wb = {a[0], r[0]};
    if (!st) begin
      if (v && !(fl || pend_m)) begin
        e.v = 1'b1; e.wb = {a[0], r[0]}; e.mem = m; e.alu = a; e.d2 = ~a; e.rd = r;
      end else begin
        e = bubble();
      end
      q1.push_back(e);
      q3.push_back(e);
      pend_m = 1'b0;
    end else if (fl) begin
      pend_m = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({a_valid, a_wb, a_mr, a_mw, a_alu, a_d2, a_rd} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%0b wb=%0b mr=%0b mw=%0b alu=%h d2=%h rd=%0d, want all 0",
               a_valid, a_wb, a_mr, a_mw, a_alu, a_d2, a_rd);
    end
    total++;
    if (a_fp !== 1'b0 || a_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_state: got fp=%0b cnt=%0d, want fp=0 cnt=0", a_fp, a_cnt);
    end
    total++;
    if (b_valid !== 1'b0 || b_alu !== 32'h0 || c_cnt !== 4'h0) begin
      bad++;
      $display("FAIL reset_other: got d3 v=%0b alu=%h c_cnt=%0d, want 0 0 0", b_valid, b_alu, c_cnt);
    end
  endtask

  task automatic test_pass_through();
    exp_t e;
    cycle(1'b1, 1'b0, 1'b0, 2'b10, 32'h1234_5678, 5'd7);
    e = q1.pop_front();
    total++;
    if (a_alu !== 32'h1234_5678 || a_mw !== 1'b1 || a_mr !== 1'b0 || a_rd !== 5'd7 || a_valid !== 1'b1) begin
      bad++;
      $display("FAIL pass_basic: got alu=%h mw=%0b mr=%0b rd=%0d v=%0b, want 12345678 1 0 7 1",
               a_alu, a_mw, a_mr, a_rd, a_valid);
    end
    total++;
    if (a_d2 !== e.d2 || a_wb !== e.wb) begin
      bad++;
      $display("FAIL pass_fields: got d2=%h wb=%0b, want d2=%h wb=%0b", a_d2, a_wb, e.d2, e.wb);
    end
    // An invalid input enters as a bubble; then a read+write instruction.
    cycle(1'b0, 1'b0, 1'b0, 2'b11, 32'h5555_AAAA, 5'd9);
    e = q1.pop_front();
    total++;
    if (a_valid !== 1'b0 || a_alu !== 32'h0 || a_d2 !== 32'h0 || a_mr !== 1'b0 || a_mw !== 1'b0 || a_rd !== 5'd0) begin
      bad++;
      $display("FAIL pass_invalid: got v=%0b alu=%h d2=%h mr=%0b mw=%0b rd=%0d, want all 0",
               a_valid, a_alu, a_d2, a_mr, a_mw, a_rd);
    end
    cycle(1'b1, 1'b0, 1'b0, 2'b11, 32'h0F0F_0F0F, 5'd31);
    e = q1.pop_front();
    total++;
    if (a_valid !== e.v || a_alu !== e.alu || a_mr !== 1'b1 || a_mw !== 1'b1 || a_rd !== e.rd || a_wb !== e.wb) begin
      bad++;
      $display("FAIL pass_rw: got v=%0b alu=%h mr=%0b mw=%0b rd=%0d wb=%0b, want 1 %h 1 1 %0d %0b",
               a_valid, a_alu, a_mr, a_mw, a_rd, a_wb, e.alu, e.rd, e.wb);
    end
  endtask

  task automatic test_stall_hold();
    exp_t e;
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 2'b00, 32'hA, 5'd1);
    e = q1.pop_front();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 2'b00, 32'hB, 5'd2);
      total++;
      if (a_alu !== 32'hA || a_valid !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold%0d: got alu=%h v=%0b, want alu=a v=1", i, a_alu, a_valid);
      end
    end
    total++;
    if (a_cnt !== 16'd3) begin
      bad++;
      $display("FAIL stall_count: got %0d, want 3", a_cnt);
    end
    cycle(1'b1, 1'b0, 1'b0, 2'b00, 32'hB, 5'd2);
    e = q1.pop_front();
    total++;
    if (a_alu !== 32'hB || a_rd !== 5'd2 || a_valid !== e.v) begin
      bad++;
      $display("FAIL stall_release: got alu=%h rd=%0d v=%0b, want b 2 1", a_alu, a_rd, a_valid);
    end
  endtask

  task automatic test_deferred_flush();
    exp_t e;
    cycle(1'b1, 1'b1, 1'b1, 2'b00, 32'h99, 5'd3);
    cycle(1'b1, 1'b1, 1'b0, 2'b00, 32'h99, 5'd3);
    total++;
    if (a_fp !== 1'b1 || a_alu !== 32'hB) begin
      bad++;
      $display("FAIL dflush_pend: got fp=%0b alu=%h, want fp=1 alu=b", a_fp, a_alu);
    end
    cycle(1'b1, 1'b0, 1'b0, 2'b01, 32'hC, 5'd4);
    e = q1.pop_front();
    total++;
    if (a_valid !== 1'b0 || a_mr !== 1'b0 || a_alu !== 32'h0 || a_fp !== 1'b0) begin
      bad++;
      $display("FAIL dflush_bubble: got v=%0b mr=%0b alu=%h fp=%0b, want 0 0 0 0", a_valid, a_mr, a_alu, a_fp);
    end
    cycle(1'b1, 1'b0, 1'b0, 2'b01, 32'hD, 5'd5);
    e = q1.pop_front();
    total++;
    if (a_valid !== 1'b1 || a_mr !== 1'b1 || a_alu !== e.alu || a_rd !== 5'd5) begin
      bad++;
      $display("FAIL dflush_next: got v=%0b mr=%0b alu=%h rd=%0d, want 1 1 d 5", a_valid, a_mr, a_alu, a_rd);
    end
    total++;
    if (a_cnt !== 16'd5) begin
      bad++;
      $display("FAIL dflush_count: got %0d, want 5", a_cnt);
    end
  endtask

  task automatic test_reset_discard();
    exp_t e;
    cycle(1'b1, 1'b1, 1'b1, 2'b00, 32'h66, 5'd6);
    do_reset();
    total++;
    if (a_fp !== 1'b0 || a_cnt !== 16'd0) begin
      bad++;
      $display("FAIL rdiscard_state: got fp=%0b cnt=%0d, want 0 0", a_fp, a_cnt);
    end
    cycle(1'b1, 1'b0, 1'b0, 2'b10, 32'h77, 5'd8);
    e = q1.pop_front();
    total++;
    if (a_valid !== 1'b1 || a_alu !== 32'h77 || a_mw !== 1'b1) begin
      bad++;
      $display("FAIL rdiscard_load: got v=%0b alu=%h mw=%0b, want 1 77 1", a_valid, a_alu, a_mw);
    end
  endtask

  task automatic test_depth();
    exp_t e;
    logic        sv [9] = '{1, 1, 1, 0, 0, 1, 1, 0, 0};
    logic        ss [9] = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
    logic        sf [9] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
    logic [31:0] sa [9] = '{32'hA0, 32'hB0, 32'hC0, 32'hF1, 32'hF2, 32'hD0, 32'hE0, 32'h0, 32'h0};
    int          seen_valid = 0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(sv[i], ss[i], sf[i], 2'(i), sa[i], 5'(i + 10));
      if (ss[i]) begin
        total++;
        if (b_alu !== 32'hA0 || b_valid !== 1'b1) begin
          bad++;
          $display("FAIL depth_stall%0d: got alu=%h v=%0b, want a0 1", i, b_alu, b_valid);
        end
      end else if (q3.size() == 3) begin
        e = q3.pop_front();
        if (b_valid === 1'b1) seen_valid++;
        total++;
        if (b_valid !== e.v || b_alu !== e.alu || b_d2 !== e.d2 || b_rd !== e.rd ||
            b_mr !== (e.v & e.mem[0]) || b_mw !== (e.v & e.mem[1]) || b_wb !== e.wb) begin
          bad++;
          $display("FAIL depth_edge%0d: got v=%0b alu=%h rd=%0d mr=%0b mw=%0b, want v=%0b alu=%h rd=%0d",
                   i, b_valid, b_alu, b_rd, b_mr, b_mw, e.v, e.alu, e.rd);
        end
      end
    end
    // A, B, C and E emerge; D was bubbled.
    total++;
    if (seen_valid != 4) begin
      bad++;
      $display("FAIL depth_valid_count: got %0d, want 4", seen_valid);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 5'd0);
      if (i == 14) begin
        total++;
        if (c_cnt !== 4'hE) begin
          bad++;
          $display("FAIL sat_pre: got %h, want e", c_cnt);
        end
      end
    end
    total++;
    if (c_cnt !== 4'hF || a_cnt !== 16'd20) begin
      bad++;
      $display("FAIL sat_hold: got c_cnt=%h a_cnt=%0d, want f 20", c_cnt, a_cnt);
    end
    do_reset();
    total++;
    if (c_cnt !== 4'h0) begin
      bad++;
      $display("FAIL sat_reset: got %h, want 0", c_cnt);
    end
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0; valid = 1'b0;
    wb = 2'b00; mem = 2'b00; alu = 32'h0; d2 = 32'h0; rd = 5'd0;
    pend_m = 1'b0;
    test_reset();
    test_pass_through();
    test_stall_hold();
    test_deferred_flush();
    test_reset_discard();
    test_depth();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
